// File: rtl/demod_pkg.sv
// Shared types and constants for the demodulator stream controller slice.
package demod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IN    = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_RES   = 3'd3,
    ST_LOAD       = 3'd4,
    ST_WAIT_SPLIT = 3'd5
  } state_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_CNT_W       = 16;

  // Packed word layout {I, Q} at the default sample width
  localparam int I_MSB = 2 * DEF_WIDTH - 1;
  localparam int Q_MSB = DEF_WIDTH - 1;

endpackage

// File: rtl/demod_stream_ctrl_if.sv
// Merge-input, demodulator and serializer signals of the stream controller.
interface demod_stream_ctrl_if #(
  parameter int WIDTH = demod_pkg::DEF_WIDTH
);

  logic                   merge_finished_i;
  logic [2*WIDTH-1:0]     merge_data_i;
  logic                   dem_valid_o;
  logic [2*WIDTH-1:0]     dem_data_o;
  logic                   dem_ready_i;
  logic                   dem_res_valid_i;
  logic [WIDTH-1:0]       dem_res_i;
  logic                   split_load_o;
  logic [2*WIDTH-1:0]     split_data_o;
  logic                   split_busy_i;

  modport master (
    input  merge_finished_i,
    input  merge_data_i,
    output dem_valid_o,
    output dem_data_o,
    input  dem_ready_i,
    input  dem_res_valid_i,
    input  dem_res_i,
    output split_load_o,
    output split_data_o,
    input  split_busy_i
  );

  modport slave (
    output merge_finished_i,
    output merge_data_i,
    input  dem_valid_o,
    input  dem_data_o,
    output dem_ready_i,
    output dem_res_valid_i,
    output dem_res_i,
    input  split_load_o,
    input  split_data_o,
    output split_busy_i
  );

endinterface

// File: rtl/sample_hold_reg.sv
// Single-entry holding register for words arriving while the pipeline is busy,
// with saturating drop counter and sticky overrun flag.
module sample_hold_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    wr_data,
  output logic [DW-1:0]    rd_data,
  output logic             full,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overrun
);

  logic [DW-1:0]    data_r;
  logic             full_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic             overrun_r;

  // Entry, full flag and drop statistics; a push with a same-cycle pop refills the entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r     <= {DW{1'b0}};
      full_r     <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
      overrun_r  <= 1'b0;
    end else if (clear) begin
      full_r <= 1'b0;
    end else if (push && (!full_r || pop)) begin
      data_r <= wr_data;
      full_r <= 1'b1;
    end else if (push) begin
      if (drop_cnt_r != {CNT_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
      overrun_r <= 1'b1;
    end else if (pop) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign rd_data  = data_r;
  assign full     = full_r;
  assign drop_cnt = drop_cnt_r;
  assign overrun  = overrun_r;

endmodule

// File: rtl/demod_stream_ctrl.sv
// Sequences merged {I,Q} words through the FM demodulator (or loopback) into the
// UART serializer, with one-word overflow buffering and a result timeout.
module demod_stream_ctrl
  import demod_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                loopback_i,
  demod_stream_ctrl_if.master bus,
  output logic [CNT_W-1:0]    sample_cnt_o,
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic                overrun_o,
  output logic                timeout_o
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e               state_r;
  logic                 mode_r;
  logic [2*WIDTH-1:0]   work_r;
  logic [2*WIDTH-1:0]   split_data_r;
  logic                 dem_valid_r;
  logic                 split_load_r;
  logic [TO_W-1:0]      to_cnt_r;
  logic [CNT_W-1:0]     sample_cnt_r;
  logic                 timeout_r;

  logic                 hold_full_s;
  logic [2*WIDTH-1:0]   hold_data_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 clear_s;
  logic [2*WIDTH-1:0]   in_word_s;

  // Route incoming pulses to the holding register; in WAIT_IN an empty holder lets words pass straight through
  always_comb begin
    clear_s = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (!start_i) begin
      clear_s = 1'b1;
    end else if (state_r == ST_WAIT_IN) begin
      pop_s  = hold_full_s;
      push_s = bus.merge_finished_i && hold_full_s;
    end else if (state_r != ST_IDLE) begin
      push_s = bus.merge_finished_i;
    end else begin
      push_s = 1'b0;
    end
  end

  // Older held word always has priority over the word arriving this cycle
  always_comb begin
    in_word_s = bus.merge_data_i;
    if (hold_full_s) begin
      in_word_s = hold_data_s;
    end else begin
      in_word_s = bus.merge_data_i;
    end
  end

  sample_hold_reg #(
    .DW    (2 * WIDTH),
    .CNT_W (CNT_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .push     (push_s),
    .pop      (pop_s),
    .wr_data  (bus.merge_data_i),
    .rd_data  (hold_data_s),
    .full     (hold_full_s),
    .drop_cnt (drop_cnt_o),
    .overrun  (overrun_o)
  );

  // Main sequencing FSM with registered handshake and load outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      mode_r       <= 1'b0;
      work_r       <= {(2*WIDTH){1'b0}};
      split_data_r <= {(2*WIDTH){1'b0}};
      dem_valid_r  <= 1'b0;
      split_load_r <= 1'b0;
      to_cnt_r     <= {TO_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
      timeout_r    <= 1'b0;
    end else begin
      split_load_r <= 1'b0;
      if (!start_i) begin
        state_r     <= ST_IDLE;
        dem_valid_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            mode_r  <= loopback_i;
            state_r <= ST_WAIT_IN;
          end
          ST_WAIT_IN: begin
            if (hold_full_s || bus.merge_finished_i) begin
              work_r <= in_word_s;
              if (mode_r) begin
                split_data_r <= in_word_s;
                state_r      <= ST_LOAD;
              end else begin
                dem_valid_r <= 1'b1;
                state_r     <= ST_ISSUE;
              end
            end else begin
              state_r <= ST_WAIT_IN;
            end
          end
          ST_ISSUE: begin
            if (dem_valid_r && bus.dem_ready_i) begin
              dem_valid_r <= 1'b0;
              to_cnt_r    <= {TO_W{1'b0}};
              state_r     <= ST_WAIT_RES;
            end else begin
              state_r <= ST_ISSUE;
            end
          end
          ST_WAIT_RES: begin
            if (bus.dem_res_valid_i) begin
              split_data_r <= {bus.dem_res_i, {WIDTH{1'b0}}};
              state_r      <= ST_LOAD;
            end else if (to_cnt_r == TO_LAST) begin
              timeout_r <= 1'b1;
              state_r   <= ST_WAIT_IN;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          ST_LOAD: begin
            split_load_r <= 1'b1;
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            state_r      <= ST_WAIT_SPLIT;
          end
          ST_WAIT_SPLIT: begin
            if (!bus.split_busy_i) begin
              state_r <= ST_WAIT_IN;
            end else begin
              state_r <= ST_WAIT_SPLIT;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            dem_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dem_valid_o  = dem_valid_r;
  assign bus.dem_data_o   = work_r;
  assign bus.split_load_o = split_load_r;
  assign bus.split_data_o = split_data_r;
  assign sample_cnt_o     = sample_cnt_r;
  assign timeout_o        = timeout_r;

endmodule

// File: tb/tb_demod_stream_ctrl.sv
// Scoreboard bench for demod_stream_ctrl: directed vectors, queued expectations, negedge monitor.
module tb_demod_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        loopback = 1'b0;
  logic [15:0] sample_cnt;
  logic [15:0] drop_cnt;
  logic        overrun;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;

  logic [31:0] exp_split[$];
  logic [31:0] exp_dem[$];

  demod_stream_ctrl_if #(.WIDTH(16)) bus ();

  demod_stream_ctrl #(
    .WIDTH       (16),
    .TIMEOUT_CYC (8),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .loopback_i   (loopback),
    .bus          (bus),
    .sample_cnt_o (sample_cnt),
    .drop_cnt_o   (drop_cnt),
    .overrun_o    (overrun),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] word);
    bus.merge_finished_i = 1'b1;
    bus.merge_data_i     = word;
    tick();
    bus.merge_finished_i = 1'b0;
  endtask

  task automatic wait_loads(input int target, input string name);
    int n = 0;
    while (load_cnt < target && n < 300) begin
      tick();
      n++;
    end
    check(name, 64'(load_cnt), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dem_valid"}, 64'(bus.dem_valid_o), 64'd0);
    check({tag, "_dem_data"}, 64'(bus.dem_data_o), 64'd0);
    check({tag, "_split_load"}, 64'(bus.split_load_o), 64'd0);
    check({tag, "_split_data"}, 64'(bus.split_data_o), 64'd0);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  // Monitor: compare every serializer load and every demodulator handshake against the queues
  always @(negedge clk) begin
    if (rst) begin
      if (bus.split_load_o) begin
        load_cnt++;
        if (exp_split.size() == 0) begin
          check("split_unexpected", 64'(bus.split_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("split_data", 64'(bus.split_data_o), 64'(exp_split.pop_front()));
        end
      end
      if (bus.dem_valid_o && bus.dem_ready_i) begin
        if (exp_dem.size() == 0) begin
          check("dem_unexpected", 64'(bus.dem_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("dem_data_hs", 64'(bus.dem_data_o), 64'(exp_dem.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.merge_finished_i = 1'b0;
    bus.merge_data_i     = 32'h0;
    bus.dem_ready_i      = 1'b0;
    bus.dem_res_valid_i  = 1'b0;
    bus.dem_res_i        = 16'h0;
    bus.split_busy_i     = 1'b0;

    // Reset state
    repeat (3) tick();
    check_all_zero("rst");
    rst = 1'b1;

    // Loopback single word: load 2 cycles after the pulse
    loopback = 1'b1;
    start    = 1'b1;
    tick();
    exp_split.push_back(32'h1234_ABCD);
    pulse(32'h1234_ABCD);
    check("lb_no_early_load", 64'(bus.split_load_o), 64'd0);
    tick();
    check("lb_load_lat2", 64'(bus.split_load_o), 64'd1);
    check("lb_sample_cnt", 64'(sample_cnt), 64'd1);
    tick();
    check("lb_load_one_cycle", 64'(bus.split_load_o), 64'd0);

    // Demodulator path with delayed ready and delayed result
    start = 1'b0;
    tick();
    loopback = 1'b0;
    start    = 1'b1;
    tick();
    exp_dem.push_back(32'h0100_FF00);
    exp_split.push_back(32'hF800_0000);
    pulse(32'h0100_FF00);
    for (int i = 0; i < 3; i++) begin
      check("dm_valid_hold", 64'(bus.dem_valid_o), 64'd1);
      check("dm_data_hold", 64'(bus.dem_data_o), 64'h0100_FF00);
      tick();
    end
    bus.dem_ready_i = 1'b1;
    tick();
    bus.dem_ready_i = 1'b0;
    check("dm_valid_drop", 64'(bus.dem_valid_o), 64'd0);
    repeat (4) tick();
    bus.dem_res_valid_i = 1'b1;
    bus.dem_res_i       = 16'hF800;
    tick();
    bus.dem_res_valid_i = 1'b0;
    wait_loads(2, "dm_load");
    repeat (5) tick();
    check("dm_single_load", 64'(load_cnt), 64'd2);
    check("dm_sample_cnt", 64'(sample_cnt), 64'd2);

    // Overrun: three pulses while the serializer is busy
    start = 1'b0;
    tick();
    loopback = 1'b1;
    start    = 1'b1;
    tick();
    bus.split_busy_i = 1'b1;
    exp_split.push_back(32'hAAAA_0001);
    exp_split.push_back(32'hBBBB_0002);
    pulse(32'hAAAA_0001);
    tick();
    pulse(32'hBBBB_0002);
    tick();
    pulse(32'hCCCC_0003);
    tick();
    pulse(32'hDDDD_0004);
    check("ov_drop_cnt", 64'(drop_cnt), 64'd2);
    check("ov_overrun", 64'(overrun), 64'd1);
    check("ov_no_load_busy", 64'(load_cnt), 64'd3);
    repeat (92) tick();
    bus.split_busy_i = 1'b0;
    wait_loads(4, "ov_held_load");
    check("ov_drop_kept", 64'(drop_cnt), 64'd2);
    check("ov_sample_cnt", 64'(sample_cnt), 64'd4);

    // Timeout with TIMEOUT_CYC=8, then recovery
    repeat (3) tick();
    start = 1'b0;
    tick();
    loopback = 1'b0;
    start    = 1'b1;
    tick();
    bus.dem_ready_i = 1'b1;
    exp_dem.push_back(32'h5555_6666);
    pulse(32'h5555_6666);
    tick();
    repeat (7) tick();
    check("to_not_yet", 64'(timeout), 64'd0);
    tick();
    check("to_flag", 64'(timeout), 64'd1);
    check("to_no_load", 64'(load_cnt), 64'd4);
    exp_dem.push_back(32'h7777_8888);
    exp_split.push_back(32'h1357_0000);
    pulse(32'h7777_8888);
    tick();
    bus.dem_ready_i     = 1'b0;
    bus.dem_res_valid_i = 1'b1;
    bus.dem_res_i       = 16'h1357;
    tick();
    bus.dem_res_valid_i = 1'b0;
    wait_loads(5, "to_recover_load");
    check("to_sample_cnt", 64'(sample_cnt), 64'd5);

    // Asynchronous reset during WAIT_RES
    repeat (3) tick();
    bus.dem_ready_i = 1'b1;
    exp_dem.push_back(32'h0F0F_F0F0);
    pulse(32'h0F0F_F0F0);
    tick();
    bus.dem_ready_i = 1'b0;
    tick();
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("arst");
    loopback = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    exp_split.push_back(32'h2468_ACE0);
    pulse(32'h2468_ACE0);
    wait_loads(6, "arst_load");
    check("arst_sample_cnt", 64'(sample_cnt), 64'd1);
    check("arst_timeout", 64'(timeout), 64'd0);

    // start_i dropped in ISSUE; pulses in IDLE ignored
    repeat (3) tick();
    start = 1'b0;
    tick();
    loopback = 1'b0;
    start    = 1'b1;
    tick();
    pulse(32'h9999_0000);
    check("sd_valid_up", 64'(bus.dem_valid_o), 64'd1);
    start = 1'b0;
    tick();
    check("sd_valid_down", 64'(bus.dem_valid_o), 64'd0);
    pulse(32'h1111_0000);
    tick();
    pulse(32'h2222_0000);
    check("sd_drop_cnt", 64'(drop_cnt), 64'd0);
    check("sd_overrun", 64'(overrun), 64'd0);
    loopback = 1'b1;
    start    = 1'b1;
    repeat (10) tick();
    check("sd_no_load", 64'(load_cnt), 64'd6);
    check("sd_dem_idle", 64'(bus.dem_valid_o), 64'd0);

    check("sb_split_empty", 64'(exp_split.size()), 64'd0);
    check("sb_dem_empty", 64'(exp_dem.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
